// File: rtl/jk_exc_driver.sv
// Drives a JK flip-flop through a queued sequence of target Q values and checks each result.
// Latency: push at edge n -> J/K in cycle n+1 -> done in cycle n+3; one target per 2 cycles.
// Backpressure: tgt_ready drops only when the DEPTH-entry target FIFO is full.
module jk_exc_driver #(
    parameter int DEPTH     = 4,
    parameter int DC_POLICY = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    input  logic             err_clr,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]       state;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             qm;
    logic             tgt_r;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic head;
    logic q_now;
    logic exc_j;
    logic exc_k;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign tgt_ready = ~full;
    assign push      = tgt_valid & tgt_ready;
    assign pop       = ((state == S_IDLE) || (state == S_CHECK)) && !empty;
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE) || !empty;

    // On CHECK->DRIVE the model is being updated from q_fb at the same edge, so use q_fb directly.
    assign q_now = (state == S_CHECK) ? q_fb : qm;

    always_comb begin
        exc_j = 1'b0;
        exc_k = 1'b0;
        if (DC_POLICY == 1) begin
            exc_j = q_now ? 1'b1 : head;
            exc_k = q_now ? ~head : 1'b1;
        end else begin
            exc_j = ~q_now & head;
            exc_k = q_now & ~head;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            qm      <= 1'b0;
            tgt_r   <= 1'b0;
            J       <= 1'b0;
            K       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            done <= (state == S_CHECK);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_DRIVE;
                        tgt_r <= head;
                        J     <= exc_j;
                        K     <= exc_k;
                    end
                end
                S_DRIVE: begin
                    state <= S_CHECK;
                    J     <= 1'b0;
                    K     <= 1'b0;
                end
                S_CHECK: begin
                    qm <= q_fb;
                    if (pop) begin
                        state <= S_DRIVE;
                        tgt_r <= head;
                        J     <= exc_j;
                        K     <= exc_k;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    J     <= 1'b0;
                    K     <= 1'b0;
                end
            endcase

            // Clear wins over a mismatch landing on the same edge.
            if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end else if ((state == S_CHECK) && (q_fb != tgt_r)) begin
                err <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_exc_driver.sv
// Directed bench: two drivers (minimal / J=K=1 don't-care fill, 8-bit / 2-bit counters)
// each closing the loop through a behavioural JK flip-flop, optionally with q_fb stuck low.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jk_exc_driver;

    logic clk = 1'b0;
    logic rst;
    logic tgt_valid;
    logic tgt_bit;
    logic err_clr;
    logic tie_low;

    logic rdy0, j0, k0, b0, d0, e0;
    logic rdy1, j1, k1, b1, d1, e1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic ff0, ff1;
    logic q_fb0, q_fb1;

    int n_checks = 0;
    int n_fail   = 0;
    int dc0 = 0;
    int dc1 = 0;
    int acc;
    logic seen_full;

    logic [4:0] t1 = 5'b10011;
    logic [1:0] exp_jk0 [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] exp_jk1 [5] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};

    always #5 clk = ~clk;

    assign q_fb0 = tie_low ? 1'b0 : ff0;
    assign q_fb1 = tie_low ? 1'b0 : ff1;

    jk_exc_driver #(.DEPTH(4), .DC_POLICY(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(rdy0),
        .q_fb(q_fb0), .err_clr(err_clr), .J(j0), .K(k0), .busy(b0), .done(d0),
        .err(e0), .err_cnt(cnt0)
    );

    jk_exc_driver #(.DEPTH(4), .DC_POLICY(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(rdy1),
        .q_fb(q_fb1), .err_clr(err_clr), .J(j1), .K(k1), .busy(b1), .done(d1),
        .err(e1), .err_cnt(cnt1)
    );

    // Driven flip-flops share the reset so their Q starts at 0 like the model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ff0 <= 1'b0;
            ff1 <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b01:   ff0 <= 1'b0;
                2'b10:   ff0 <= 1'b1;
                2'b11:   ff0 <= ~ff0;
                default: ff0 <= ff0;
            endcase
            case ({j1, k1})
                2'b01:   ff1 <= 1'b0;
                2'b10:   ff1 <= 1'b1;
                2'b11:   ff1 <= ~ff1;
                default: ff1 <= ff1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (d0) dc0 = dc0 + 1;
        if (d1) dc1 = dc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        tgt_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dc0 = 0;
        dc1 = 0;
    endtask

    task automatic push_bits(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tgt_valid = 1'b1;
            tgt_bit   = bits[i];
            @(negedge clk);
        end
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (!b0 && !b1) idle = 1'b1;
        end
        if (!idle) chk(tag, 32'(b0), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;
        err_clr   = 1'b0;
        tie_low   = 1'b0;

        // Reset state, with a push offered throughout reset
        #1 rst = 1'b1;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        #1;
        chk("rst_jk", 32'({j0, k0, j1, k1}), 32'd0);
        chk("rst_busy", 32'({b0, b1}), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'({rdy0, rdy1}), 32'd3);
        chk("rst_flags", 32'({d0, e0, d1, e1}), 32'd0);
        chk("rst_cnt", 32'({cnt0, cnt1}), 32'd0);
        tgt_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_push_ignored", 32'({b0, b1}), 32'd0);

        // Closed-loop sequence 1,1,0,0,1 pushed back to back
        do_reset();
        tgt_valid = 1'b1;
        tgt_bit   = t1[0];
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k < 5) tgt_bit = t1[k];
            else tgt_valid = 1'b0;
            if (k >= 2 && k <= 10 && (k % 2) == 0) begin
                chk("seq_jk_min", 32'({j0, k0}), 32'(exp_jk0[(k-2)/2]));
                chk("seq_jk_dc1", 32'({j1, k1}), 32'(exp_jk1[(k-2)/2]));
            end
            if (k == 3) chk("seq_done_early", 32'(d0), 32'd0);
            if (k == 4) chk("seq_done_lat", 32'(d0), 32'd1);
        end
        chk("seq_done_cnt0", 32'(dc0), 32'd5);
        chk("seq_done_cnt1", 32'(dc1), 32'd5);
        chk("seq_err", 32'({e0, e1}), 32'd0);
        chk("seq_final_q", 32'({q_fb0, q_fb1}), 32'd3);
        chk("seq_idle_jk", 32'({j0, k0, j1, k1}), 32'd0);

        // Feedback stuck low: mismatches, clear, saturation
        do_reset();
        tie_low = 1'b1;
        push_bits(8'b011, 3);
        wait_idle("stuck_idle_timeout");
        chk("stuck_err", 32'({e0, e1}), 32'd3);
        chk("stuck_cnt0", 32'(cnt0), 32'd2);
        chk("stuck_cnt1", 32'(cnt1), 32'd2);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", 32'({e0, e1}), 32'd0);
        chk("clr_cnt", 32'({cnt0, cnt1}), 32'd0);
        push_bits(8'b11111, 5);
        wait_idle("sat_idle_timeout");
        chk("sat_cnt0", 32'(cnt0), 32'd5);
        chk("sat_cnt1", 32'(cnt1), 32'd3);
        chk("sat_done_cnt", 32'(dc1), 32'd8);
        tie_low = 1'b0;

        // Continuous offer until full; the value offered while full must be dropped
        do_reset();
        acc = 0;
        seen_full = 1'b0;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        for (int i = 0; i < 20 && !seen_full; i++) begin
            if (rdy0) acc = acc + 1;
            @(negedge clk);
            if (!rdy0) seen_full = 1'b1;
        end
        chk("full_ready", 32'({rdy0, rdy1}), 32'd0);
        chk("full_accepted", 32'(acc), 32'd7);
        tgt_bit = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("full_ready_back", 32'(rdy0), 32'd1);
        wait_idle("full_idle_timeout");
        chk("full_done_cnt", 32'(dc0), 32'd7);
        chk("full_final_q", 32'({q_fb0, q_fb1}), 32'd3);
        chk("full_err", 32'({e0, e1}), 32'd0);

        // Reset in a DRIVE cycle with three targets queued
        do_reset();
        push_bits(8'b111011, 6);
        chk("mid_jk_min", 32'({j0, k0}), 32'b01);
        chk("mid_jk_dc1", 32'({j1, k1}), 32'b11);
        rst = 1'b1;
        #1;
        chk("mid_rst_jk", 32'({j0, k0, j1, k1}), 32'd0);
        chk("mid_rst_busy", 32'({b0, b1}), 32'd0);
        dc0 = 0;
        dc1 = 0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_done", 32'(dc0 + dc1), 32'd0);
        rst = 1'b0;
        push_bits(8'b1, 1);
        @(negedge clk);
        chk("post_rst_jk_min", 32'({j0, k0}), 32'b10);
        chk("post_rst_jk_dc1", 32'({j1, k1}), 32'b11);
        wait_idle("post_rst_idle_timeout");
        chk("post_rst_done", 32'(dc0), 32'd1);
        chk("post_rst_err", 32'({e0, e1}), 32'd0);
        chk("post_rst_q", 32'({q_fb0, q_fb1}), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
